// File: rtl/fifo_rr_read_sched_pkg.sv
// Shared definitions for the round-robin FIFO read scheduler: default
// packet geometry (kept in line with the fifo instances), FSM state
// encodings and the rotate-priority distance helper.
package fifo_rr_read_sched_pkg;

  localparam int N_PORTS_DEF   = 4;
  localparam int WIDTH_DEF     = 11;
  localparam int UWIDTH_DEF    = 8;
  localparam int PTR_IN_SZ_DEF = 4;
  localparam int GNT_SZ_DEF    = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_POP  = 2'd2;

  // How many steps after 'last' a port sits in the rotation; the port just
  // served is the furthest away (n-1), its successor the nearest (0).
  function automatic int rr_dist(input int port, input int last, input int n);
    return (port - last - 1 + 2 * n) % n;
  endfunction

endpackage

// File: rtl/fifo_rr_read_sched_if.sv
// Bundle of the FIFO read side (empty flags, head data, pop, unit address)
// and the valid/ready unit stream towards the link serializer.
interface fifo_rr_read_sched_if #(
  parameter int N_PORTS   = 4,
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4
);

  logic [N_PORTS-1:0]        rempty;
  logic [N_PORTS*UWIDTH-1:0] rdata;
  logic [N_PORTS-1:0]        rinc;
  logic [PTR_IN_SZ-1:0]      raddr_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [UWIDTH-1:0]         out_data;
  logic                      out_sop;
  logic                      out_eop;

  modport master (
    input  rempty, rdata, out_ready,
    output rinc, raddr_in, out_valid, out_data, out_sop, out_eop
  );

  modport slave (
    output rempty, rdata, out_ready,
    input  rinc, raddr_in, out_valid, out_data, out_sop, out_eop
  );

endinterface

// File: rtl/fifo_rr_read_sched_rr_arbiter.sv
// Combinational rotate-priority encoder: among the requesting ports, picks
// the one closest after 'last' in the round-robin order (mod N_PORTS).
module rr_arbiter
  import fifo_rr_read_sched_pkg::*;
#(
  parameter int N_PORTS = N_PORTS_DEF,
  parameter int GNT_SZ  = GNT_SZ_DEF
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [GNT_SZ-1:0]  last,
  output logic [GNT_SZ-1:0]  pick,
  output logic               any
);

  int best;

  // Keep the requester with the smallest rotation distance from 'last'.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    best = N_PORTS;
    for (int j = 0; j < N_PORTS; j++) begin
      if (req[j] && (rr_dist(j, int'(last), N_PORTS) < best)) begin
        best = rr_dist(j, int'(last), N_PORTS);
        pick = GNT_SZ'(j);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_read_sched.sv
// Round-robin read scheduler: grants one non-empty FIFO, streams its head
// entry unit by unit over valid/ready, then pops it with a one-cycle rinc.
module fifo_rr_read_sched
  import fifo_rr_read_sched_pkg::*;
#(
  parameter int N_PORTS   = N_PORTS_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int UWIDTH    = UWIDTH_DEF,
  parameter int PTR_IN_SZ = PTR_IN_SZ_DEF,
  parameter int GNT_SZ    = GNT_SZ_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_rr_read_sched_if.master bus,
  output logic [GNT_SZ-1:0]    gnt_idx,
  output logic                 busy
);

  localparam logic [PTR_IN_SZ-1:0] IDX_LAST = PTR_IN_SZ'(WIDTH - 1);

  logic [1:0]           state_q, state_d;
  logic [PTR_IN_SZ-1:0] idx_q, idx_d;
  logic [GNT_SZ-1:0]    gnt_q, gnt_d;
  logic [GNT_SZ-1:0]    last_q, last_d;
  logic [GNT_SZ-1:0]    pick;
  logic                 any;
  logic [N_PORTS-1:0]   req;

  assign req = ~bus.rempty;

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .GNT_SZ  (GNT_SZ)
  ) u_arb (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );

  // Next-state: grant in IDLE, step the unit index on accepted beats, pop once.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (any) begin
          gnt_d   = pick;
          idx_d   = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (bus.out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_POP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_POP: begin
        last_d  = gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state; data is a mux of the granted head.
  always_comb begin
    bus.raddr_in  = idx_q;
    bus.out_valid = (state_q == ST_XFER);
    bus.out_sop   = (state_q == ST_XFER) && (idx_q == '0);
    bus.out_eop   = (state_q == ST_XFER) && (idx_q == IDX_LAST);
    bus.out_data  = '0;
    bus.rinc      = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt_q == GNT_SZ'(i)) begin
        bus.out_data = bus.rdata[i*UWIDTH +: UWIDTH];
        bus.rinc[i]  = (state_q == ST_POP);
      end
    end
    gnt_idx = gnt_q;
    busy    = (state_q != ST_IDLE);
  end

  // State registers; reset abandons any transfer and gives port 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      gnt_q   <= '0;
      last_q  <= GNT_SZ'(N_PORTS - 1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_fifo_rr_read_sched.sv
// Testbench for fifo_rr_read_sched: behavioural FIFOs feed the scheduler,
// a packet-level model predicts every output each cycle, and directed tests
// pin grant order, beat contents, backpressure and mid-transfer reset.
module tb_fifo_rr_read_sched;

  localparam int NP    = 4;
  localparam int W     = 11;
  localparam int UW    = 8;
  localparam int PS    = 4;
  localparam int GS    = 2;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [GS-1:0] gnt_idx;
  logic          busy;

  fifo_rr_read_sched_if #(.N_PORTS(NP), .UWIDTH(UW), .PTR_IN_SZ(PS)) bus ();

  fifo_rr_read_sched #(
    .N_PORTS   (NP),
    .WIDTH     (W),
    .UWIDTH    (UW),
    .PTR_IN_SZ (PS),
    .GNT_SZ    (GS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .gnt_idx (gnt_idx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [NP][DEPTH][W];
  int         head [NP];
  int         cnt  [NP];

  int         m_beat = -1;
  int         m_port = 0;
  int         m_last = NP - 1;

  int         n_pass  = 0;
  int         n_total = 0;
  int         pop_log[$];
  logic [7:0] beat_log[$];
  logic [7:0] sop_log[$];

  // FIFO heads: empty flag from occupancy, head data addressed by raddr_in.
  always_comb begin
    bus.rempty = '0;
    bus.rdata  = '0;
    for (int i = 0; i < NP; i++) begin
      bus.rempty[i] = (cnt[i] == 0);
      if (cnt[i] != 0 && int'(bus.raddr_in) < W)
        bus.rdata[i*UW +: UW] = mem[i][head[i]][int'(bus.raddr_in)];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Packet-level model: -1 idle, 0..W-1 beat being offered, W = pop cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_beat = -1;
      m_port = 0;
      m_last = NP - 1;
    end else if (m_beat < 0) begin
      for (int k = 1; k <= NP; k++) begin
        if (cnt[(m_last + k) % NP] > 0) begin
          m_port = (m_last + k) % NP;
          m_beat = 0;
          break;
        end
      end
    end else if (m_beat == W) begin
      m_last = m_port;
      m_beat = -1;
    end else if (bus.out_ready) begin
      m_beat = m_beat + 1;
    end
  end

  // Mid-cycle compare against the model, beat capture, and FIFO pop on rinc.
  always @(negedge clk) begin
    bit exp_valid;
    exp_valid = (m_beat >= 0) && (m_beat < W);
    checkOutput("out_valid", bus.out_valid, exp_valid);
    checkOutput("busy", busy, m_beat >= 0);
    checkOutput("gnt_idx", gnt_idx, m_port);
    checkOutput("rinc", bus.rinc, (m_beat == W) ? (32'd1 << m_port) : 32'd0);
    if (exp_valid) begin
      checkOutput("raddr_in", bus.raddr_in, m_beat);
      checkOutput("out_data", bus.out_data, mem[m_port][head[m_port]][m_beat]);
      checkOutput("out_sop", bus.out_sop, m_beat == 0);
      checkOutput("out_eop", bus.out_eop, m_beat == W - 1);
    end else begin
      checkOutput("out_sop_idle", bus.out_sop, 0);
      checkOutput("out_eop_idle", bus.out_eop, 0);
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      beat_log.push_back(bus.out_data);
      if (bus.out_sop) sop_log.push_back(bus.out_data);
    end
    for (int i = 0; i < NP; i++) begin
      if (bus.rinc[i] && cnt[i] > 0) begin
        head[i] = (head[i] + 1) % DEPTH;
        cnt[i]  = cnt[i] - 1;
        pop_log.push_back(i);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Push one packet whose unit k is base+k onto a FIFO.
  task automatic applyStimulus(input int port, input logic [7:0] base);
    int wr;
    wr = (head[port] + cnt[port]) % DEPTH;
    for (int k = 0; k < W; k++) mem[port][wr][k] = base + 8'(k);
    cnt[port] = cnt[port] + 1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    pop_log.delete();
    beat_log.delete();
    sop_log.delete();
  endtask

  task automatic waitPops(input int n, input int budget);
    int c;
    c = 0;
    while (pop_log.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    if (pop_log.size() < n) checkOutput("timeout_pops", pop_log.size(), n);
    tick(2);
  endtask

  task automatic waitBeat(input int idx, input int budget);
    int c;
    c = 0;
    while (!(bus.out_valid && int'(bus.raddr_in) == idx) && c < budget) begin
      tick(1);
      c++;
    end
    if (c >= budget) checkOutput("timeout_beat", c, 0);
  endtask

  // Directed scenarios with literal expectations.
  initial begin
    int c;
    bus.out_ready = 1'b1;

    tick(2);
    checkOutput("rst_valid", bus.out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rinc", bus.rinc, 0);
    checkOutput("rst_gnt", gnt_idx, 0);
    checkOutput("rst_raddr", bus.raddr_in, 0);
    checkOutput("rst_sop_eop", {bus.out_sop, bus.out_eop}, 0);
    rst = 1'b0;
    tick(3);
    checkOutput("idle_busy", busy, 0);

    doReset();
    applyStimulus(1, 8'h20);
    c = 0;
    while (bus.rinc == '0 && c < 40) begin
      tick(1);
      c++;
      if (bus.out_valid && bus.raddr_in == 4'd10) checkOutput("t2_eop", bus.out_eop, 1);
    end
    checkOutput("t2_cycles_to_rinc", c, 12);
    checkOutput("t2_rinc", bus.rinc, 4'b0010);
    tick(1);
    checkOutput("t2_idle_after", busy, 0);
    checkOutput("t2_beats", beat_log.size(), 11);
    if (beat_log.size() == 11) begin
      checkOutput("t2_first", beat_log[0], 8'h20);
      checkOutput("t2_last", beat_log[10], 8'h2A);
    end
    checkOutput("t2_sop_data", (sop_log.size() == 1) ? sop_log[0] : 8'hFF, 8'h20);

    doReset();
    for (int e = 0; e < 2; e++)
      for (int p = 0; p < NP; p++) applyStimulus(p, 8'h40 + 8'(p * 32) + 8'(e * 16));
    waitPops(8, 200);
    for (int i = 0; i < 8; i++)
      checkOutput("t3_grant_order", (pop_log.size() > i) ? pop_log[i] : -1, i % NP);

    doReset();
    applyStimulus(0, 8'h80);
    waitBeat(5, 20);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("t4_hold_raddr", bus.raddr_in, 5);
      checkOutput("t4_hold_data", bus.out_data, 8'h85);
      checkOutput("t4_hold_rinc", bus.rinc, 0);
    end
    bus.out_ready = 1'b1;
    waitPops(1, 40);
    checkOutput("t4_beats", beat_log.size(), 11);
    checkOutput("t4_pop_port", (pop_log.size() > 0) ? pop_log[0] : -1, 0);

    doReset();
    applyStimulus(2, 8'hA0);
    waitBeat(7, 20);
    checkOutput("t5_gnt_before", gnt_idx, 2);
    applyStimulus(0, 8'h60);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("t5_no_pop", pop_log.size(), 0);
    checkOutput("t5_rinc", bus.rinc, 0);
    beat_log.delete();
    sop_log.delete();
    waitPops(2, 80);
    checkOutput("t5_pop0", (pop_log.size() > 0) ? pop_log[0] : -1, 0);
    checkOutput("t5_pop1", (pop_log.size() > 1) ? pop_log[1] : -1, 2);
    checkOutput("t5_sop0", (sop_log.size() > 0) ? sop_log[0] : 8'hFF, 8'h60);
    checkOutput("t5_sop1", (sop_log.size() > 1) ? sop_log[1] : 8'hFF, 8'hA0);
    checkOutput("t5_beats", beat_log.size(), 22);

    doReset();
    applyStimulus(0, 8'h10);
    applyStimulus(0, 8'h30);
    applyStimulus(3, 8'hC0);
    waitPops(3, 120);
    checkOutput("t6_grant0", (pop_log.size() > 0) ? pop_log[0] : -1, 0);
    checkOutput("t6_grant1", (pop_log.size() > 1) ? pop_log[1] : -1, 3);
    checkOutput("t6_grant2", (pop_log.size() > 2) ? pop_log[2] : -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
